// File: rtl/mc_pkg.sv
// Shared constants and FSM encoding for the multi-core processor and its program loader.
package mc_pkg;

  localparam int CORE_COUNT          = 3;
  localparam int REG_WIDTH           = 12;
  localparam int INS_WIDTH           = 8;
  localparam int INS_MEM_DEPTH       = 256;
  localparam int DATA_MEM_DEPTH      = 4096;
  localparam int DATA_MEM_WIDTH      = REG_WIDTH * CORE_COUNT;
  localparam int INS_MEM_ADDR_WIDTH  = $clog2(INS_MEM_DEPTH);
  localparam int DATA_MEM_ADDR_WIDTH = $clog2(DATA_MEM_DEPTH);

  // Bytes per data word on the wire; the surplus top bits of the first byte are dropped.
  localparam int BPW = (DATA_MEM_WIDTH + 7) / 8;

  // Header fields are 16-bit big-endian counts.
  localparam int HDR_FIELD_BYTES = 2;
  localparam int HDR_FIELD_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_LD_INS,
    ST_LD_DAT,
    ST_START,
    ST_RUN,
    ST_ERR
  } loader_state_e;

endpackage

// File: rtl/byte_packer.sv
// Assembles NBYTES big-endian bytes into one word, keeping only the low OUT_WIDTH bits.
// word_valid_o / word_o are combinational and valid in the cycle of the completing byte.
module byte_packer #(
  parameter int NBYTES    = 5,
  parameter int OUT_WIDTH = 36
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 clr_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_i,
  output logic                 word_valid_o,
  output logic [OUT_WIDTH-1:0] word_o
);

  localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  // Only OUT_WIDTH-8 bits of history are needed: anything older falls off the top,
  // which is exactly the truncation of the over-wide wire word.
  logic [OUT_WIDTH-9:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  assign word_o       = {shift_q, byte_i};
  assign word_valid_o = byte_valid_i && (cnt_q == LAST_IDX);

  // Next-state: shift in each byte, restart the byte count after a full word or on clear.
  always_comb begin
    // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_valid_i) begin
      shift_d = word_o[OUT_WIDTH-9:0];
      cnt_d   = word_valid_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads instruction and data memory from a framed byte stream, then starts the
// processor and waits for it to finish. Owns the memory write ports while memSel=1.
module program_loader
  import mc_pkg::*;
#(
  parameter int CORE_COUNT     = mc_pkg::CORE_COUNT,
  parameter int REG_WIDTH      = mc_pkg::REG_WIDTH,
  parameter int INS_WIDTH      = mc_pkg::INS_WIDTH,
  parameter int INS_MEM_DEPTH  = mc_pkg::INS_MEM_DEPTH,
  parameter int DATA_MEM_DEPTH = mc_pkg::DATA_MEM_DEPTH,
  localparam int DMW = REG_WIDTH * CORE_COUNT,
  localparam int IAW = $clog2(INS_MEM_DEPTH),
  localparam int DAW = $clog2(DATA_MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [7:0]           rxData,
  input  logic                 rxValid,
  input  logic                 procDone,
  output logic                 insWrEn,
  output logic [IAW-1:0]       insWrAddr,
  output logic [INS_WIDTH-1:0] insWrData,
  output logic                 dataWrEn,
  output logic [DAW-1:0]       dataWrAddr,
  output logic [DMW-1:0]       dataWrData,
  output logic                 memSel,
  output logic                 procStartN,
  output logic                 busy,
  output logic                 finished,
  output logic                 error
);

  localparam int BYTES_PER_WORD = (DMW + 7) / 8;

  loader_state_e state_q, state_d;

  logic [HDR_FIELD_WIDTH-1:0] ni_q, ni_d;
  logic [HDR_FIELD_WIDTH-1:0] nd_q, nd_d;
  logic                       hdr_idx_q, hdr_idx_d;
  logic [IAW:0]               ins_cnt_q, ins_cnt_d;
  logic [DAW:0]               dat_cnt_q, dat_cnt_d;

  logic                 ins_we_q, ins_we_d;
  logic [IAW-1:0]       ins_addr_q, ins_addr_d;
  logic [INS_WIDTH-1:0] ins_data_q, ins_data_d;
  logic                 dat_we_q, dat_we_d;
  logic [DAW-1:0]       dat_addr_q, dat_addr_d;
  logic [DMW-1:0]       dat_data_q, dat_data_d;
  logic                 mem_sel_q, mem_sel_d;
  logic                 start_n_q, start_n_d;
  logic                 busy_q, busy_d;
  logic                 finished_q, finished_d;
  logic                 error_q, error_d;

  logic                       hdr_word_valid;
  logic [HDR_FIELD_WIDTH-1:0] hdr_word;
  logic                       dat_word_valid;
  logic [DMW-1:0]             dat_word;

  // Packers are held clear outside their own state, so each state entry starts from byte 0.
  byte_packer #(.NBYTES(HDR_FIELD_BYTES), .OUT_WIDTH(HDR_FIELD_WIDTH)) u_hdr_packer (
    .clk          (clk),
    .rstN         (rstN),
    .clr_i        (state_q != ST_HDR),
    .byte_valid_i (rxValid && (state_q == ST_HDR)),
    .byte_i       (rxData),
    .word_valid_o (hdr_word_valid),
    .word_o       (hdr_word)
  );

  byte_packer #(.NBYTES(BYTES_PER_WORD), .OUT_WIDTH(DMW)) u_dat_packer (
    .clk          (clk),
    .rstN         (rstN),
    .clr_i        (state_q != ST_LD_DAT),
    .byte_valid_i (rxValid && (state_q == ST_LD_DAT)),
    .byte_i       (rxData),
    .word_valid_o (dat_word_valid),
    .word_o       (dat_word)
  );

  // Frame FSM: next state and registered outputs.
  always_comb begin
    state_d    = state_q;
    ni_d       = ni_q;
    nd_d       = nd_q;
    hdr_idx_d  = (state_q == ST_HDR) ? hdr_idx_q : 1'b0;
    ins_cnt_d  = ins_cnt_q;
    dat_cnt_d  = dat_cnt_q;
    ins_we_d   = 1'b0;
    ins_addr_d = ins_addr_q;
    ins_data_d = ins_data_q;
    dat_we_d   = 1'b0;
    dat_addr_d = dat_addr_q;
    dat_data_d = dat_data_q;
    mem_sel_d  = mem_sel_q;
    start_n_d  = 1'b1;
    busy_d     = busy_q;
    finished_d = 1'b0;
    error_d    = error_q;

    unique case (state_q)
      ST_HDR: begin
        if (rxValid) busy_d = 1'b1;
        if (hdr_word_valid) begin
          if (!hdr_idx_q) begin
            ni_d      = hdr_word;
            hdr_idx_d = 1'b1;
          end else begin
            nd_d      = hdr_word;
            hdr_idx_d = 1'b0;
            ins_cnt_d = '0;
            dat_cnt_d = '0;
            if (ni_q > HDR_FIELD_WIDTH'(INS_MEM_DEPTH) ||
                hdr_word > HDR_FIELD_WIDTH'(DATA_MEM_DEPTH)) begin
              state_d = ST_ERR;
              error_d = 1'b1;
              busy_d  = 1'b0;
            end else if (ni_q != '0) begin
              state_d = ST_LD_INS;
            end else if (hdr_word != '0) begin
              state_d = ST_LD_DAT;
            end else begin
              state_d = ST_START;
            end
          end
        end
      end

      ST_LD_INS: begin
        if (rxValid) begin
          ins_we_d   = 1'b1;
          ins_addr_d = ins_cnt_q[IAW-1:0];
          ins_data_d = rxData[INS_WIDTH-1:0];
          ins_cnt_d  = ins_cnt_q + (IAW+1)'(1);
          // The count is bounded by the header check, so the address never wraps.
          if (HDR_FIELD_WIDTH'(ins_cnt_q) + HDR_FIELD_WIDTH'(1) == ni_q)
            state_d = (nd_q != '0) ? ST_LD_DAT : ST_START;
        end
      end

      ST_LD_DAT: begin
        if (dat_word_valid) begin
          dat_we_d   = 1'b1;
          dat_addr_d = dat_cnt_q[DAW-1:0];
          dat_data_d = dat_word;
          dat_cnt_d  = dat_cnt_q + (DAW+1)'(1);
          if (HDR_FIELD_WIDTH'(dat_cnt_q) + HDR_FIELD_WIDTH'(1) == nd_q)
            state_d = ST_START;
        end
      end

      // The last load write lands during START, so the hand-over happens one cycle later.
      ST_START: begin
        mem_sel_d = 1'b0;
        start_n_d = 1'b0;
        state_d   = ST_RUN;
      end

      ST_RUN: begin
        if (procDone) begin
          finished_d = 1'b1;
          mem_sel_d  = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_HDR;
        end
      end

      ST_ERR: begin
        error_d   = 1'b1;
        mem_sel_d = 1'b1;
        busy_d    = 1'b0;
      end

      default: state_d = ST_HDR;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= ST_HDR;
      ni_q       <= '0;
      nd_q       <= '0;
      hdr_idx_q  <= 1'b0;
      ins_cnt_q  <= '0;
      dat_cnt_q  <= '0;
      ins_we_q   <= 1'b0;
      ins_addr_q <= '0;
      ins_data_q <= '0;
      dat_we_q   <= 1'b0;
      dat_addr_q <= '0;
      dat_data_q <= '0;
      mem_sel_q  <= 1'b1;
      start_n_q  <= 1'b1;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ni_q       <= ni_d;
      nd_q       <= nd_d;
      hdr_idx_q  <= hdr_idx_d;
      ins_cnt_q  <= ins_cnt_d;
      dat_cnt_q  <= dat_cnt_d;
      ins_we_q   <= ins_we_d;
      ins_addr_q <= ins_addr_d;
      ins_data_q <= ins_data_d;
      dat_we_q   <= dat_we_d;
      dat_addr_q <= dat_addr_d;
      dat_data_q <= dat_data_d;
      mem_sel_q  <= mem_sel_d;
      start_n_q  <= start_n_d;
      busy_q     <= busy_d;
      finished_q <= finished_d;
      error_q    <= error_d;
    end
  end

  assign insWrEn    = ins_we_q;
  assign insWrAddr  = ins_addr_q;
  assign insWrData  = ins_data_q;
  assign dataWrEn   = dat_we_q;
  assign dataWrAddr = dat_addr_q;
  assign dataWrData = dat_data_q;
  assign memSel     = mem_sel_q;
  assign procStartN = start_n_q;
  assign busy       = busy_q;
  assign finished   = finished_q;
  assign error      = error_q;

endmodule
